// File: rtl/matmul_pkg.sv
// Shared definitions for the 3x3 matrix multiplier front end.
// Holds the loader state encoding, the matrix geometry and the counter widths.
package matmul_pkg;

    localparam int unsigned N         = 3;
    localparam int unsigned ELEM_W    = 8;
    localparam int unsigned NUM_ELEMS = N * N;
    localparam int unsigned NUM_OPS   = 2 * NUM_ELEMS;
    localparam int unsigned COUNT_W   = 5;
    localparam int unsigned JOBS_W    = 8;

    typedef enum logic [1:0] {
        StLoad = 2'b00,
        StFire = 2'b01,
        StWait = 2'b10
    } state_e;

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Bundle between the operand source / multiplier and the operand loader.
//   clear, in_data, in_valid : element stream and discard request into the loader
//   in_ready                 : loader can take an element
//   A, B                     : packed operand matrices to the multiplier
//   start, done              : job handshake with the multiplier
//   busy, count, jobs        : loader status
// master is the loader's view, slave is the environment's view.
interface matrix_operand_loader_if;
    import matmul_pkg::*;

    logic                        clear;
    logic [ELEM_W-1:0]           in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_ELEMS*ELEM_W-1:0] A;
    logic [NUM_ELEMS*ELEM_W-1:0] B;
    logic                        start;
    logic                        done;
    logic                        busy;
    logic [COUNT_W-1:0]          count;
    logic [JOBS_W-1:0]           jobs;

    modport master (
        input  clear, in_data, in_valid, done,
        output in_ready, A, B, start, busy, count, jobs
    );

    modport slave (
        output clear, in_data, in_valid, done,
        input  in_ready, A, B, start, busy, count, jobs
    );

endinterface

// File: rtl/matrix_operand_loader.sv
// Operand loader for the 3x3 matrix multiplier.
// Packs 18 streamed bytes into A (elements 0..8) and B (elements 9..17), pulses start
// for one cycle, then holds A/B stable until the multiplier reports done.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : loader side of matrix_operand_loader_if (stream in, operands/start out)
module matrix_operand_loader #(
    parameter int unsigned N      = 3,
    parameter int unsigned ELEM_W = 8
) (
    input logic                      clk,
    input logic                      reset,
    matrix_operand_loader_if.master  bus
);
    import matmul_pkg::*;

    localparam int unsigned NumElems = N * N;
    localparam int unsigned NumOps   = 2 * NumElems;
    localparam int unsigned MatW     = NumElems * ELEM_W;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [JOBS_W-1:0]  jobs_q, jobs_d;
    logic [MatW-1:0]    a_q, a_d;
    logic [MatW-1:0]    b_q, b_d;
    logic               start_q, start_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLoad;
            count_q <= '0;
            jobs_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            jobs_q  <= jobs_d;
            a_q     <= a_d;
            b_q     <= b_d;
            start_q <= start_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        jobs_d  = jobs_q;
        a_d     = a_q;
        b_d     = b_q;
        start_d = 1'b0;
        unique case (state_q)
            StLoad: begin
                // clear wins over in_valid and drops the partial job
                if (bus.clear) begin
                    count_d = '0;
                    a_d     = '0;
                    b_d     = '0;
                end else if (bus.in_valid) begin
                    for (int i = 0; i < int'(NumElems); i++) begin
                        if (count_q == COUNT_W'(i)) begin
                            a_d[i*ELEM_W +: ELEM_W] = bus.in_data;
                        end
                        if (count_q == COUNT_W'(i + int'(NumElems))) begin
                            b_d[i*ELEM_W +: ELEM_W] = bus.in_data;
                        end
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == COUNT_W'(NumOps - 1)) begin
                        state_d = StFire;
                        start_d = 1'b1;
                    end
                end
            end
            StFire: begin
                state_d = StWait;
            end
            StWait: begin
                // done is only trusted here: the multiplier cleared any stale level
                // on the edge that sampled start
                if (bus.done) begin
                    state_d = StLoad;
                    count_d = '0;
                    jobs_d  = jobs_q + 1'b1;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready = (state_q == StLoad) && !bus.clear;
        bus.busy     = (state_q == StFire) || (state_q == StWait);
        bus.start    = start_q;
        bus.count    = count_q;
        bus.jobs     = jobs_q;
        bus.A        = a_q;
        bus.B        = b_q;
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
module tb_matrix_operand_loader;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [7:0] m_a [9];
    logic [7:0] m_b [9];
    int         m_count;
    logic [7:0] m_jobs;

    matrix_operand_loader_if bus ();

    matrix_operand_loader #(
        .N      (3),
        .ELEM_W (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] pack(input logic [7:0] m [9]);
        logic [71:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p[i*8 +: 8] = m[i];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 9; i++) begin
            m_a[i] = 8'h00;
            m_b[i] = 8'h00;
        end
        m_count = 0;
    endtask

    // Offer one element at a negedge, let the next posedge accept it.
    task automatic load_elem(input logic [7:0] d);
        chk("start_idle", {71'd0, bus.start}, 72'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        chk("in_ready_load", {71'd0, bus.in_ready}, 72'd1);
        @(negedge clk);
        if (m_count < 9) m_a[m_count] = d;
        else             m_b[m_count-9] = d;
        m_count++;
        bus.in_valid = 1'b0;
        chk("count_load", {67'd0, bus.count}, 72'(m_count));
        chk("A_load", bus.A, pack(m_a));
        chk("B_load", bus.B, pack(m_b));
        chk("jobs_load", {64'd0, bus.jobs}, {64'd0, m_jobs});
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) load_elem(8'($urandom));
    endtask

    // Called at the negedge right after the 18th accept.
    task automatic check_fire();
        chk("start_fire", {71'd0, bus.start}, 72'd1);
        chk("busy_fire", {71'd0, bus.busy}, 72'd1);
        chk("count_fire", {67'd0, bus.count}, 72'd18);
        chk("in_ready_fire", {71'd0, bus.in_ready}, 72'd0);
    endtask

    // From the FIRE negedge: wait w cycles in WAIT, then raise done. done is left high
    // afterwards like a real multiplier, so every next load runs with a stale done.
    task automatic finish_job(input int w, input logic clr);
        @(negedge clk);
        bus.done = 1'b0;
        chk("start_wait", {71'd0, bus.start}, 72'd0);
        chk("busy_wait", {71'd0, bus.busy}, 72'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        bus.clear    = clr;
        for (int i = 0; i < w; i++) begin
            #1;
            chk("in_ready_wait", {71'd0, bus.in_ready}, 72'd0);
            @(negedge clk);
            chk("count_wait", {67'd0, bus.count}, 72'd18);
            chk("jobs_wait", {64'd0, bus.jobs}, {64'd0, m_jobs});
            chk("busy_hold", {71'd0, bus.busy}, 72'd1);
        end
        bus.done = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        m_jobs  = m_jobs + 8'd1;
        m_count = 0;
        chk("busy_done", {71'd0, bus.busy}, 72'd0);
        chk("count_done", {67'd0, bus.count}, 72'd0);
        chk("jobs_done", {64'd0, bus.jobs}, {64'd0, m_jobs});
        chk("A_held", bus.A, pack(m_a));
        #1;
        chk("in_ready_done", {71'd0, bus.in_ready}, 72'd1);
    endtask

    task automatic check_reset_state();
        chk("rst_count", {67'd0, bus.count}, 72'd0);
        chk("rst_jobs", {64'd0, bus.jobs}, 72'd0);
        chk("rst_A", bus.A, 72'd0);
        chk("rst_B", bus.B, 72'd0);
        chk("rst_start", {71'd0, bus.start}, 72'd0);
        chk("rst_busy", {71'd0, bus.busy}, 72'd0);
        chk("rst_in_ready", {71'd0, bus.in_ready}, 72'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_jobs = 8'd0;
        model_clear();
        reset        = 1'b1;
        bus.clear    = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.done     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back load, A=1..9, B=9..1
        for (int i = 1; i <= 9; i++) load_elem(8'(i));
        for (int i = 9; i >= 1; i--) load_elem(8'(i));
        check_fire();
        chk("A_fixed", bus.A, 72'h090807060504030201);
        chk("B_fixed", bus.B, 72'h010203040506070809);

        // Backpressure through WAIT
        finish_job(4, 1'b0);
        load_elem(8'h5A);
        chk("job2_a0", {64'd0, bus.A[7:0]}, 72'h5A);
        load_random(17);
        check_fire();

        // clear during WAIT has no effect
        finish_job(2, 1'b1);

        // clear in LOAD at count 5, with in_valid high
        load_random(5);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        #1;
        chk("in_ready_clear", {71'd0, bus.in_ready}, 72'd0);
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        chk("count_clear", {67'd0, bus.count}, 72'd0);
        chk("A_clear", bus.A, 72'd0);
        chk("B_clear", bus.B, 72'd0);
        load_random(17);
        chk("no_start_17", {71'd0, bus.start}, 72'd0);
        load_random(1);
        check_fire();
        finish_job(1, 1'b0);

        // Reset mid-load at count 12
        load_random(12);
        #1;
        reset = 1'b1;
        #1;
        model_clear();
        m_jobs = 8'd0;
        check_reset_state();
        @(negedge clk);
        reset = 1'b0;

        // 256 jobs: jobs wraps back to 0
        for (int j = 0; j < 256; j++) begin
            load_random(18);
            check_fire();
            finish_job(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        chk("jobs_wrap", {64'd0, bus.jobs}, 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
